// File: rtl/event_blink.sv
// Event-driven LED blinker: every accepted event produces one fixed-length blink
// followed by a minimum off-gap; events arriving during a blink are queued.
module event_blink #(
  parameter int unsigned ON_CYCLES  = 5000000,
  parameter int unsigned OFF_CYCLES = 5000000,
  parameter int unsigned PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              event_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [23:0] ON_LOAD  = 24'(ON_CYCLES - 1);
  localparam logic [23:0] OFF_LOAD = 24'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            r_state;
  logic [23:0]       r_cnt;
  logic              r_led;
  logic              r_busy;
  logic [PEND_W-1:0] r_pend;
  logic              r_ovf;

  state_t            w_state;
  logic [23:0]       w_cnt;
  logic [PEND_W-1:0] w_pend;
  logic              w_ovf;
  logic              w_inc;
  logic              w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_pend  = r_pend;
    w_ovf   = r_ovf;
    w_inc   = 1'b0;

    case (r_state)
      IDLE: begin
        if (event_in) begin
          w_state = ON;
          w_cnt   = ON_LOAD;
        end
      end

      ON: begin
        w_inc = event_in;
        if (w_cnt_zero) begin
          w_state = GAP;
          w_cnt   = OFF_LOAD;
        end else begin
          w_cnt = r_cnt - 24'd1;
        end
      end

      GAP: begin
        if (w_cnt_zero) begin
          // Exit edge: a queued event wins; a same-edge event then replaces the
          // one consumed, otherwise a fresh event starts the blink directly.
          if (r_pend != '0) begin
            w_state = ON;
            w_cnt   = ON_LOAD;
            if (!event_in) begin
              w_pend = r_pend - 1'b1;
            end
          end else if (event_in) begin
            w_state = ON;
            w_cnt   = ON_LOAD;
          end else begin
            w_state = IDLE;
          end
        end else begin
          w_cnt = r_cnt - 24'd1;
          w_inc = event_in;
        end
      end

      default: begin
        w_state = IDLE;
        w_cnt   = '0;
        w_pend  = '0;
      end
    endcase

    if (w_inc) begin
      if (r_pend == '1) begin
        w_ovf = 1'b1;
      end else begin
        w_pend = r_pend + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_led   <= (w_state == ON);
      r_busy  <= (w_state != IDLE);
      r_pend  <= w_pend;
      r_ovf   <= w_ovf;
    end
  end

  assign led_out  = r_led;
  assign busy     = r_busy;
  assign pending  = r_pend;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_event_blink.sv
// Directed bench for event_blink with ON_CYCLES=3, OFF_CYCLES=2, PEND_W=4.
module tb_event_blink;

  logic       clk;
  logic       rst;
  logic       event_in;
  logic       led_out;
  logic       busy;
  logic [3:0] pending;
  logic       overflow;

  int n_err;
  int n_chk;
  int n_blinks;
  int b0;
  int waited;

  event_blink #(
    .ON_CYCLES (3),
    .OFF_CYCLES(2),
    .PEND_W    (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .event_in(event_in),
    .led_out (led_out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge led_out) n_blinks++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One rising edge with event_in driven to ev; returns 1 time unit after the edge.
  task automatic step(input logic ev);
    event_in = ev;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    waited = 0;
    while (busy && waited < budget) begin
      step(1'b0);
      waited++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_err    = 0;
    n_chk    = 0;
    n_blinks = 0;
    rst      = 1'b1;
    event_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_led",  {31'd0, led_out},  32'd0);
    chk("rst_busy", {31'd0, busy},     32'd0);
    chk("rst_pend", {28'd0, pending},  32'd0);
    chk("rst_ovf",  {31'd0, overflow}, 32'd0);
    rst = 1'b0;

    // Single pulse
    step(1'b1);
    chk("single_e0_led",  {31'd0, led_out}, 32'd1);
    chk("single_e0_busy", {31'd0, busy},    32'd1);
    step(1'b0);
    step(1'b0);
    chk("single_e2_led",  {31'd0, led_out}, 32'd1);
    step(1'b0);
    chk("single_e3_led",  {31'd0, led_out}, 32'd0);
    chk("single_e3_busy", {31'd0, busy},    32'd1);
    step(1'b0);
    chk("single_e4_busy", {31'd0, busy},    32'd1);
    step(1'b0);
    chk("single_e5_busy", {31'd0, busy},    32'd0);

    // Two pulses back to back
    step(1'b1);
    step(1'b1);
    chk("two_e1_pend", {28'd0, pending}, 32'd1);
    repeat (3) step(1'b0);
    chk("two_e4_led", {31'd0, led_out}, 32'd0);
    step(1'b0);
    chk("two_e5_led",  {31'd0, led_out}, 32'd1);
    chk("two_e5_pend", {28'd0, pending}, 32'd0);
    step(1'b0);
    step(1'b0);
    chk("two_e7_led", {31'd0, led_out}, 32'd1);
    step(1'b0);
    chk("two_e8_led", {31'd0, led_out}, 32'd0);
    step(1'b0);
    chk("two_e9_busy", {31'd0, busy}, 32'd1);
    step(1'b0);
    chk("two_e10_busy", {31'd0, busy}, 32'd0);

    // Pending=1 plus an event on the gap-exit edge
    step(1'b1);
    step(1'b1);
    repeat (3) step(1'b0);
    step(1'b1);
    chk("exitp_e5_led",  {31'd0, led_out}, 32'd1);
    chk("exitp_e5_pend", {28'd0, pending}, 32'd1);
    repeat (5) step(1'b0);
    chk("exitp_e10_led",  {31'd0, led_out}, 32'd1);
    chk("exitp_e10_pend", {28'd0, pending}, 32'd0);
    repeat (5) step(1'b0);
    chk("exitp_e15_busy", {31'd0, busy}, 32'd0);

    // Pending=0 plus an event on the gap-exit edge
    step(1'b1);
    repeat (4) step(1'b0);
    step(1'b1);
    chk("exit0_e5_led",  {31'd0, led_out}, 32'd1);
    chk("exit0_e5_pend", {28'd0, pending}, 32'd0);
    repeat (5) step(1'b0);
    chk("exit0_e10_busy", {31'd0, busy}, 32'd0);

    // event_in held for 10 cycles: exit edges 5 consume and accept, net pending 8
    b0 = n_blinks;
    repeat (10) step(1'b1);
    chk("hold10_pend", {28'd0, pending}, 32'd8);
    wait_idle("hold10_idle", 100);
    chk("hold10_blinks", n_blinks - b0, 32'd10);

    // Saturation: 20 held cycles, exits at 5,10,15 leave pending 15 after edge 18
    b0 = n_blinks;
    repeat (19) step(1'b1);
    chk("sat_e18_pend", {28'd0, pending},  32'd15);
    chk("sat_e18_ovf",  {31'd0, overflow}, 32'd0);
    step(1'b1);
    chk("sat_e19_pend", {28'd0, pending},  32'd15);
    chk("sat_e19_ovf",  {31'd0, overflow}, 32'd1);
    wait_idle("sat_idle", 200);
    chk("sat_blinks",    n_blinks - b0,     32'd19);
    chk("sat_ovf_stick", {31'd0, overflow}, 32'd1);
    chk("sat_idle_pend", {28'd0, pending},  32'd0);

    // Asynchronous reset mid-ON with pending=3
    repeat (5) step(1'b1);
    step(1'b0);
    chk("arst_pre_led",  {31'd0, led_out}, 32'd1);
    chk("arst_pre_pend", {28'd0, pending}, 32'd3);
    b0 = n_blinks;
    #3 rst = 1'b1;
    #1;
    chk("arst_led",  {31'd0, led_out},  32'd0);
    chk("arst_busy", {31'd0, busy},     32'd0);
    chk("arst_pend", {28'd0, pending},  32'd0);
    chk("arst_ovf",  {31'd0, overflow}, 32'd0);
    event_in = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_ev_ignored", {31'd0, busy}, 32'd0);
    event_in = 1'b0;
    rst      = 1'b0;
    repeat (20) step(1'b0);
    chk("arst_no_blinks", n_blinks - b0, 32'd0);
    chk("arst_led_quiet", {31'd0, led_out}, 32'd0);
    step(1'b1);
    chk("post_rst_start", {31'd0, led_out}, 32'd1);
    wait_idle("post_rst_idle", 20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
